// File: rtl/write_back_stage_if.sv
// Bundle of write-back stage signals: ALU/load result inputs plus the
// register-file write port and buffer status outputs.
interface write_back_stage_if #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3,
    parameter int FIFO_DEPTH        = 4
);
    localparam int COUNT_BITS = $clog2(FIFO_DEPTH) + 1;

    logic                         in_alu_valid_flag;
    logic [REG_INDEX_BITS-1:0]    in_alu_reg_index;
    logic [THREAD_INDEX_BITS-1:0] in_alu_thread_index;
    logic [DATA_WIDTH-1:0]        in_alu_data;

    logic                         in_load_valid_flag;
    logic [REG_INDEX_BITS-1:0]    in_load_reg_index;
    logic [THREAD_INDEX_BITS-1:0] in_load_thread_index;
    logic [DATA_WIDTH-1:0]        in_load_data;

    logic                         out_load_ready_flag;
    logic                         out_write_back_enable_flag;
    logic [REG_INDEX_BITS-1:0]    out_write_back_reg_index;
    logic [THREAD_INDEX_BITS-1:0] out_write_back_thread_index;
    logic [DATA_WIDTH-1:0]        out_write_back_data;
    logic [COUNT_BITS-1:0]        out_fifo_count;
    logic                         out_overflow_flag;

    // Upstream side: produces results, observes the write port.
    modport master (
        output in_alu_valid_flag, in_alu_reg_index, in_alu_thread_index, in_alu_data,
        output in_load_valid_flag, in_load_reg_index, in_load_thread_index, in_load_data,
        input  out_load_ready_flag, out_write_back_enable_flag, out_write_back_reg_index,
        input  out_write_back_thread_index, out_write_back_data, out_fifo_count,
        input  out_overflow_flag
    );

    // Write-back stage side.
    modport slave (
        input  in_alu_valid_flag, in_alu_reg_index, in_alu_thread_index, in_alu_data,
        input  in_load_valid_flag, in_load_reg_index, in_load_thread_index, in_load_data,
        output out_load_ready_flag, out_write_back_enable_flag, out_write_back_reg_index,
        output out_write_back_thread_index, out_write_back_data, out_fifo_count,
        output out_overflow_flag
    );
endinterface

// File: rtl/write_back_stage.sv
// Final pipeline stage: merges never-stalled ALU results with buffered load
// returns onto one registered register-file write port.
module write_back_stage #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    write_back_stage_if.slave        bus
);
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int COUNT_BITS = PTR_BITS + 1;

    typedef struct packed {
        logic [REG_INDEX_BITS-1:0]    reg_index;
        logic [THREAD_INDEX_BITS-1:0] thread_index;
        logic [DATA_WIDTH-1:0]        data;
    } entry_t;

    entry_t                 mem_q [FIFO_DEPTH];
    entry_t                 mem_d [FIFO_DEPTH];
    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [COUNT_BITS-1:0]  count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   we_q, we_d;
    entry_t                 wb_q, wb_d;

    logic                   ready;
    logic                   load_accept;
    logic                   push;
    logic                   pop;
    entry_t                 alu_entry;
    entry_t                 load_entry;

    // Ready depends only on registered count so upstream sees no comb path.
    assign ready       = (count_q != COUNT_BITS'(FIFO_DEPTH));
    assign load_accept = bus.in_load_valid_flag && ready;

    assign alu_entry  = '{reg_index:    bus.in_alu_reg_index,
                          thread_index: bus.in_alu_thread_index,
                          data:         bus.in_alu_data};
    assign load_entry = '{reg_index:    bus.in_load_reg_index,
                          thread_index: bus.in_load_thread_index,
                          data:         bus.in_load_data};

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        we_d       = 1'b0;
        wb_d       = wb_q;
        overflow_d = overflow_q || (bus.in_load_valid_flag && !ready);

        if (bus.in_alu_valid_flag) begin
            we_d = 1'b1;
            wb_d = alu_entry;
            push = load_accept;
        end else if (count_q != '0) begin
            we_d = 1'b1;
            wb_d = mem_q[rd_ptr_q];
            pop  = 1'b1;
            push = load_accept;
        end else if (load_accept) begin
            // Empty buffer and idle ALU: skip the FIFO entirely.
            we_d = 1'b1;
            wb_d = load_entry;
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = load_entry;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
        count_d  = count_q + COUNT_BITS'(push) - COUNT_BITS'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            wb_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            we_q       <= we_d;
            wb_q       <= wb_d;
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_load_ready_flag         = ready;
    assign bus.out_write_back_enable_flag  = we_q;
    assign bus.out_write_back_reg_index    = wb_q.reg_index;
    assign bus.out_write_back_thread_index = wb_q.thread_index;
    assign bus.out_write_back_data         = wb_q.data;
    assign bus.out_fifo_count              = count_q;
    assign bus.out_overflow_flag           = overflow_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: expected writes go into a scoreboard
// queue, a negedge monitor pops and compares every asserted write.
module tb_write_back_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    write_back_stage_if #(.DATA_WIDTH(64), .REG_INDEX_BITS(5),
                          .THREAD_INDEX_BITS(3), .FIFO_DEPTH(4)) bus ();

    write_back_stage #(.DATA_WIDTH(64), .REG_INDEX_BITS(5),
                       .THREAD_INDEX_BITS(3), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  r;
        logic [2:0]  t;
        logic [63:0] d;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] r, input logic [2:0] t, input logic [63:0] d);
        wb_t e;
        e.r = r; e.t = t; e.d = d;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs; return just after the capturing edge.
    task automatic cyc(input logic av, input logic [4:0] ar, input logic [2:0] at,
                       input logic [63:0] ad, input logic lv, input logic [4:0] lr,
                       input logic [2:0] lt, input logic [63:0] ld);
        bus.in_alu_valid_flag    = av;
        bus.in_alu_reg_index     = ar;
        bus.in_alu_thread_index  = at;
        bus.in_alu_data          = ad;
        bus.in_load_valid_flag   = lv;
        bus.in_load_reg_index    = lr;
        bus.in_load_thread_index = lt;
        bus.in_load_data         = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 3'd0, 64'd0, 1'b0, 5'd0, 3'd0, 64'd0);
    endtask

    always @(negedge clk) begin
        if (bus.out_write_back_enable_flag === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual reg=%0d thr=%0d data=0x%0h required=none",
                         bus.out_write_back_reg_index, bus.out_write_back_thread_index,
                         bus.out_write_back_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_reg",  64'(bus.out_write_back_reg_index),    64'(e.r));
                check("wb_thr",  64'(bus.out_write_back_thread_index), 64'(e.t));
                check("wb_data", bus.out_write_back_data,              e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        idle();
        check("rst_we",       64'(bus.out_write_back_enable_flag), 64'd0);
        check("rst_count",    64'(bus.out_fifo_count),             64'd0);
        check("rst_ready",    64'(bus.out_load_ready_flag),        64'd1);
        check("rst_overflow", 64'(bus.out_overflow_flag),          64'd0);

        // Single ALU result, one-cycle latency
        expect_wb(5'd3, 3'd2, 64'h5);
        cyc(1'b1, 5'd3, 3'd2, 64'h5, 1'b0, 5'd0, 3'd0, 64'd0);
        check("alu_we_n1", 64'(bus.out_write_back_enable_flag), 64'd1);
        idle();
        check("alu_we_n2", 64'(bus.out_write_back_enable_flag), 64'd0);

        // Load bypass with empty FIFO
        expect_wb(5'd7, 3'd1, 64'hAA);
        cyc(1'b0, 5'd0, 3'd0, 64'd0, 1'b1, 5'd7, 3'd1, 64'hAA);
        check("byp_we",    64'(bus.out_write_back_enable_flag), 64'd1);
        check("byp_count", 64'(bus.out_fifo_count),             64'd0);
        idle();
        check("byp_count2", 64'(bus.out_fifo_count),            64'd0);

        // ALU and load collide: ALU first, load buffered
        expect_wb(5'd1, 3'd0, 64'h10);
        expect_wb(5'd2, 3'd0, 64'h20);
        cyc(1'b1, 5'd1, 3'd0, 64'h10, 1'b1, 5'd2, 3'd0, 64'h20);
        check("col_we1",    64'(bus.out_write_back_enable_flag), 64'd1);
        check("col_count1", 64'(bus.out_fifo_count),             64'd1);
        idle();
        check("col_we2",    64'(bus.out_write_back_enable_flag), 64'd1);
        check("col_count2", 64'(bus.out_fifo_count),             64'd0);
        idle();
        check("col_we3",    64'(bus.out_write_back_enable_flag), 64'd0);

        // Simultaneous push and pop keeps count and order
        expect_wb(5'd4, 3'd6, 64'h40);
        expect_wb(5'd5, 3'd6, 64'h50);
        expect_wb(5'd6, 3'd6, 64'h60);
        cyc(1'b1, 5'd4, 3'd6, 64'h40, 1'b1, 5'd5, 3'd6, 64'h50);
        check("pp_count1", 64'(bus.out_fifo_count), 64'd1);
        cyc(1'b0, 5'd0, 3'd0, 64'd0, 1'b1, 5'd6, 3'd6, 64'h60);
        check("pp_count2", 64'(bus.out_fifo_count), 64'd1);
        idle();
        check("pp_count3", 64'(bus.out_fifo_count), 64'd0);

        // Fill past capacity under continuous ALU traffic
        for (int i = 1; i <= 6; i++) begin
            expect_wb(5'd10, 3'd3, 64'h100 + 64'(i));
            cyc(1'b1, 5'd10, 3'd3, 64'h100 + 64'(i), 1'b1, 5'(16 + i), 3'd5, 64'(i));
            check("fill_count", 64'(bus.out_fifo_count), 64'((i < 4) ? i : 4));
            check("fill_ready", 64'(bus.out_load_ready_flag), 64'((i < 4) ? 1 : 0));
            check("fill_overflow", 64'(bus.out_overflow_flag), 64'((i < 5) ? 0 : 1));
        end
        for (int i = 1; i <= 4; i++) expect_wb(5'(16 + i), 3'd5, 64'(i));
        for (int i = 1; i <= 4; i++) begin
            idle();
            check("drain_we",    64'(bus.out_write_back_enable_flag), 64'd1);
            check("drain_count", 64'(bus.out_fifo_count),             64'(4 - i));
        end
        idle();
        check("drain_done_we", 64'(bus.out_write_back_enable_flag), 64'd0);
        check("overflow_sticky", 64'(bus.out_overflow_flag),          64'd1);

        // Mid-operation reset discards buffered entries
        for (int i = 0; i < 3; i++) begin
            expect_wb(5'd11, 3'd7, 64'h200 + 64'(i));
            cyc(1'b1, 5'd11, 3'd7, 64'h200 + 64'(i), 1'b1, 5'd12, 3'd7, 64'hDEAD0 + 64'(i));
        end
        check("pre_rst_count", 64'(bus.out_fifo_count), 64'd3);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("mid_rst_count",    64'(bus.out_fifo_count),             64'd0);
        check("mid_rst_we",       64'(bus.out_write_back_enable_flag), 64'd0);
        check("mid_rst_overflow", 64'(bus.out_overflow_flag),          64'd0);
        check("mid_rst_ready",    64'(bus.out_load_ready_flag),        64'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("post_rst_we", 64'(bus.out_write_back_enable_flag), 64'd0);
        end

        // Normal operation resumes after reset
        expect_wb(5'd9, 3'd4, 64'hBEEF);
        cyc(1'b0, 5'd0, 3'd0, 64'd0, 1'b1, 5'd9, 3'd4, 64'hBEEF);
        check("resume_we", 64'(bus.out_write_back_enable_flag), 64'd1);
        idle();
        idle();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
